// File: rtl/acumulador_pkg.sv
// acumulador_pkg: shared mode encoding and sizing helper
// for the parametrised accumulator and its prescaler.
package acumulador_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Counter width needed to hold 0..div-1 (at least 1 bit).
  function automatic int presc_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/acumulador_presc.sv
// acumulador_presc: divide-by-DIV tick generator.
// Ports: clk, rst (sync, high), enable in; tick out.
module acumulador_presc
  import acumulador_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int PW = presc_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Phase freezes while enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/acumulador_param.sv
// acumulador_param: WIDTH-bit up/down/accumulate/load register
// with prescaled updates, registered carry/borrow pulse and
// terminal-count flag. Ports: clk, rst, enable, mode, add_in,
// add_valid, sat in; add_ready, out, cout, tc out.
// Build option: ACUM_SATURATE_EN makes sat clamp on overflow.
module acumulador_param
  import acumulador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] add_in,
  input  logic             add_valid,
  output logic             add_ready,
  input  logic             sat,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             tc
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);

  mode_t            m;
  logic             tick;
  logic             upd;
  logic             carry;
  logic [WIDTH:0]   res;
  logic [WIDTH-1:0] nxt;

  assign m = mode_t'(mode);

  acumulador_presc #(
    .DIV (DIV)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign add_ready = tick & mode[1];

  // Extra top bit of res is the carry (add) or borrow (sub).
  always_comb begin
    res = {1'b0, out};
    upd = tick;
    unique case (m)
      MODE_UP:   res = {1'b0, out} + STEP_X;
      MODE_DOWN: res = {1'b0, out} - STEP_X;
      MODE_ACC: begin
        res = {1'b0, out} + {1'b0, add_in};
        upd = tick & add_valid;
      end
      MODE_LOAD: begin
        res = {1'b0, add_in};
        upd = tick & add_valid;
      end
    endcase
    carry = res[WIDTH] & (m != MODE_LOAD);
    nxt   = res[WIDTH-1:0];
`ifdef ACUM_SATURATE_EN
    if (sat && carry) begin
      nxt = (m == MODE_DOWN) ? '0 : '1;
    end
`endif
  end

`ifndef ACUM_SATURATE_EN
  logic unused_sat;
  assign unused_sat = sat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out  <= '0;
      cout <= 1'b0;
    end else begin
      cout <= upd & carry;
      if (upd) begin
        out <= nxt;
      end
    end
  end

  always_comb begin
    tc = 1'b0;
    unique case (m)
      MODE_UP:   tc = (out == '1);
      MODE_DOWN: tc = (out == '0);
      default:   tc = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_acumulador_param.sv
// tb_acumulador_param: directed checks on four parameter sets
// sharing one stimulus stream.
module tb_acumulador_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] add_in;
  logic       add_valid;
  logic       sat;

  logic [7:0] o_a, o_b, o_c, o_d;
  logic       c_a, c_b, c_c, c_d;
  logic       t_a, t_b, t_c, t_d;
  logic       r_a, r_b, r_c, r_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: STEP 1 DIV 1
  acumulador_param #(.WIDTH(8), .STEP(1), .DIV(1)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .add_in(add_in), .add_valid(add_valid), .add_ready(r_a),
    .sat(sat), .out(o_a), .cout(c_a), .tc(t_a)
  );
  // B: STEP 1 DIV 4
  acumulador_param #(.WIDTH(8), .STEP(1), .DIV(4)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .add_in(add_in), .add_valid(add_valid), .add_ready(r_b),
    .sat(sat), .out(o_b), .cout(c_b), .tc(t_b)
  );
  // C: STEP 3 DIV 1
  acumulador_param #(.WIDTH(8), .STEP(3), .DIV(1)) u_c (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .add_in(add_in), .add_valid(add_valid), .add_ready(r_c),
    .sat(sat), .out(o_c), .cout(c_c), .tc(t_c)
  );
  // D: STEP 5 DIV 1
  acumulador_param #(.WIDTH(8), .STEP(5), .DIV(1)) u_d (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .add_in(add_in), .add_valid(add_valid), .add_ready(r_d),
    .sat(sat), .out(o_d), .cout(c_d), .tc(t_d)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Load v into every DIV=1 instance.
  task automatic load(input logic [7:0] v);
    enable    = 1'b1;
    mode      = 2'b11;
    add_in    = v;
    add_valid = 1'b1;
    step();
    add_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'b00;
    add_in = 8'h00; add_valid = 1'b0; sat = 1'b0;

    // reset, then full hold with a live addend offered
    step();
    step();
    check("rst_out", o_a, 8'h00);
    check("rst_cout", c_a, 1'b0);
    check("rst_rdy", r_a, 1'b0);
    rst = 1'b0; mode = 2'b10; add_in = 8'h55; add_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_out", o_a, 8'h00);
      check("hold_cout", c_a, 1'b0);
      check("hold_rdy", r_a, 1'b0);
    end

    // up wrap on A
    enable = 1'b1; mode = 2'b11; add_in = 8'hFE; add_valid = 1'b1;
    #1;
    check("ld_rdy", r_a, 1'b1);
    step();
    check("ld_out", o_a, 8'hFE);
    check("ld_cout", c_a, 1'b0);
    add_valid = 1'b0; mode = 2'b00;
    #1;
    check("up_tc0", t_a, 1'b0);
    check("up_rdy", r_a, 1'b0);
    step();
    check("up_ff", o_a, 8'hFF);
    check("up_tc1", t_a, 1'b1);
    check("up_c0", c_a, 1'b0);
    step();
    check("up_wrap", o_a, 8'h00);
    check("up_cout", c_a, 1'b1);
    step();
    check("up_01", o_a, 8'h01);
    check("up_c1", c_a, 1'b0);

    // prescaler DIV=4 on B
    enable = 1'b0;
    do_reset();
    enable = 1'b1; mode = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("psc_out", o_b, 16'(i / 4));
      check("psc_cout", c_b, 1'b0);
    end
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("psc_frz", o_b, 8'h03);
    end
    enable = 1'b1;
    step();
    check("psc_ph3", o_b, 8'h03);
    step();
    check("psc_tick", o_b, 8'h04);

    // accumulate handshake on A
    do_reset();
    load(8'hF0);
    check("acc_ld", o_a, 8'hF0);
    mode = 2'b10; add_in = 8'h20; add_valid = 1'b1;
    step();
    check("acc_wrap", o_a, 8'h10);
    check("acc_cout", c_a, 1'b1);
    check("acc_tc", t_a, 1'b0);
    add_valid = 1'b0;
    #1;
    check("acc_rdy", r_a, 1'b1);
    step();
    check("acc_hold", o_a, 8'h10);
    check("acc_c0", c_a, 1'b0);
    add_in = 8'h05; add_valid = 1'b1;
    step();
    check("acc_add", o_a, 8'h15);
    check("acc_nc", c_a, 1'b0);
    mode = 2'b11; add_in = 8'hFF;
    step();
    check("ld_ff", o_a, 8'hFF);
    check("ld_nc", c_a, 1'b0);
    add_valid = 1'b0;

    // down borrow on C (STEP 3)
    load(8'h01);
    mode = 2'b01;
    #1;
    check("dn_tc0", t_c, 1'b0);
    step();
    check("dn_wrap", o_c, 8'hFE);
    check("dn_cout", c_c, 1'b1);
    step();
    check("dn_fb", o_c, 8'hFB);
    check("dn_c0", c_c, 1'b0);
    load(8'h00);
    mode = 2'b01;
    #1;
    check("dn_tc1", t_c, 1'b1);

    // mid-period reset on B discards pending tick
    enable = 1'b0;
    do_reset();
    enable = 1'b1; mode = 2'b00;
    step();
    step();
    step();
    check("mr_pre", o_b, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_out", o_b, 8'h00);
    check("mr_cout", c_b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mr_wait", o_b, 8'h00);
    end
    step();
    check("mr_tick", o_b, 8'h01);

    // saturation on D (STEP 5)
    sat = 1'b1;
    load(8'hFE);
    mode = 2'b00;
    step();
`ifdef ACUM_SATURATE_EN
    check("sat_up", o_d, 8'hFF);
`else
    check("sat_up", o_d, 8'h03);
`endif
    check("sat_upc", c_d, 1'b1);
    load(8'h02);
    mode = 2'b01;
    step();
`ifdef ACUM_SATURATE_EN
    check("sat_dn", o_d, 8'h00);
`else
    check("sat_dn", o_d, 8'hFD);
`endif
    check("sat_dnc", c_d, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
